// File: rtl/lfsr32_pkg.sv
// Shared definitions for the lfsr32 PRBS checker: width, feedback taps, FSM states.
package lfsr32_pkg;
    localparam int LFSR_W = 32;
    localparam int TAP_A  = 31;
    localparam int TAP_B  = 21;
    localparam int TAP_C  = 1;
    localparam int TAP_D  = 0;
    localparam int CNT_W  = $clog2(LFSR_W);

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    // x^32+x^22+x^2+x+1 with H[0] the newest bit
    function automatic logic lfsr_fb(input logic [LFSR_W-1:0] h);
        return h[TAP_A] ^ h[TAP_B] ^ h[TAP_C] ^ h[TAP_D];
    endfunction
endpackage

// File: rtl/lfsr32_predict.sv
// 32-bit history register and next-bit prediction; shifts either the line bit
// or its own prediction (flywheel mode once locked).
module lfsr32_predict
    import lfsr32_pkg::*;
(
    input  logic Clk,
    input  logic ARstb,
    input  logic shift_en,
    input  logic load_pred,
    input  logic din,
    output logic pred
);
    logic [LFSR_W-1:0] hist;

    assign pred = lfsr_fb(hist);

    always_ff @(posedge Clk or negedge ARstb) begin
        if (!ARstb)
            hist <= '0;
        else if (shift_en)
            hist <= {hist[LFSR_W-2:0], (load_pred ? pred : din)};
    end
endmodule

// File: rtl/lfsr32_checker.sv
// Serial PRBS checker for the lfsr32 generator: SEED -> VERIFY -> LOCKED.
// Define LFSR32_CHK_BITCNT_EN to build the locked-bit counter behind BitCnt.
module lfsr32_checker
    import lfsr32_pkg::*;
#(
    parameter int ERR_THRESH = 8
) (
    input  logic        Clk,
    input  logic        ARstb,
    input  logic        En,
    input  logic        DIn,
    input  logic        ClrErr,
    output logic        Locked,
    output logic        ErrPulse,
    output logic [15:0] ErrCnt,
    output logic [31:0] BitCnt
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LFSR_W - 1);

    chk_state_e       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;          // seed count, match run or window position
    logic [5:0]       win_err, win_err_nxt;
    logic             pred, mismatch, lock_err;

    lfsr32_predict u_predict (
        .Clk       (Clk),
        .ARstb     (ARstb),
        .shift_en  (En),
        .load_pred (state == ST_LOCKED),
        .din       (DIn),
        .pred      (pred)
    );

    assign mismatch = DIn ^ pred;
    assign lock_err = En && (state == ST_LOCKED) && mismatch;
    assign Locked   = (state == ST_LOCKED);

    always_ff @(posedge Clk or negedge ARstb) begin
        if (!ARstb) state <= ST_SEED;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        win_err_nxt = win_err;
        if (En) begin
            case (state)
                ST_SEED: begin
                    cnt_nxt = cnt + 1'b1;
                    if (cnt == CNT_MAX) begin
                        state_nxt = ST_VERIFY;
                        cnt_nxt   = '0;
                    end
                end
                ST_VERIFY: begin
                    if (mismatch) begin
                        state_nxt = ST_SEED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                        if (cnt == CNT_MAX) begin
                            state_nxt   = ST_LOCKED;
                            cnt_nxt     = '0;
                            win_err_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // cnt wraps every 32 samples, closing the error window
                    cnt_nxt     = cnt + 1'b1;
                    win_err_nxt = (cnt == CNT_MAX) ? '0 : win_err + {5'd0, mismatch};
                    if (mismatch && (int'(win_err) + 1 >= ERR_THRESH)) begin
                        state_nxt   = ST_SEED;
                        cnt_nxt     = '0;
                        win_err_nxt = '0;
                    end
                end
                default: begin
                    state_nxt   = ST_SEED;
                    cnt_nxt     = '0;
                    win_err_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge ARstb) begin
        if (!ARstb) begin
            cnt      <= '0;
            win_err  <= '0;
            ErrPulse <= 1'b0;
            ErrCnt   <= '0;
        end else begin
            cnt      <= cnt_nxt;
            win_err  <= win_err_nxt;
            ErrPulse <= lock_err;
            if (ClrErr)
                ErrCnt <= '0;
            else if (lock_err && (ErrCnt != 16'hFFFF))
                ErrCnt <= ErrCnt + 16'd1;
        end
    end

`ifdef LFSR32_CHK_BITCNT_EN
    always_ff @(posedge Clk or negedge ARstb) begin
        if (!ARstb)
            BitCnt <= '0;
        else if (ClrErr)
            BitCnt <= '0;
        else if (En && (state == ST_LOCKED))
            BitCnt <= BitCnt + 32'd1;
    end
`else
    assign BitCnt = '0;
`endif
endmodule

// File: tb/tb_lfsr32_checker.sv
// Bench for lfsr32_checker: directed sync/error/reset sequences, a table of
// error-injection patterns, and randomized traffic against a queue-based model.
module tb_lfsr32_checker;
    localparam int THRESH = 8;
`ifdef LFSR32_CHK_BITCNT_EN
    localparam bit BITCNT_ON = 1'b1;
`else
    localparam bit BITCNT_ON = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        ARstb, En, DIn, ClrErr;
    logic        Locked, ErrPulse;
    logic [15:0] ErrCnt;
    logic [31:0] BitCnt;

    logic        s_rst, s_en, s_din, s_clr;
    logic        s_locked, s_pulse;
    logic [15:0] s_errcnt;
    logic [31:0] s_bitcnt;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses  = 0;

    always #5 Clk = ~Clk;

    lfsr32_checker #(.ERR_THRESH(THRESH)) dut (
        .Clk(Clk), .ARstb(ARstb), .En(En), .DIn(DIn), .ClrErr(ClrErr),
        .Locked(Locked), .ErrPulse(ErrPulse), .ErrCnt(ErrCnt), .BitCnt(BitCnt)
    );

    // threshold above the window size: lock can never be lost, so errors can saturate
    lfsr32_checker #(.ERR_THRESH(33)) dut_sat (
        .Clk(Clk), .ARstb(s_rst), .En(s_en), .DIn(s_din), .ClrErr(s_clr),
        .Locked(s_locked), .ErrPulse(s_pulse), .ErrCnt(s_errcnt), .BitCnt(s_bitcnt)
    );

    typedef struct {
        string name;
        int    nflip;
        int    gap;
        bit    exp_locked;
        int    exp_err;
    } flip_vec_t;

    flip_vec_t vecs[5];

    bit [31:0] g, sg;

    function automatic bit lfsr_step(inout bit [31:0] st);
        bit b;
        b  = st[31] ^ st[21] ^ st[1] ^ st[0];
        st = {st[30:0], b};
        return b;
    endfunction

    // reference model: mode 0 seed, 1 verify, 2 locked; history as a bit queue, oldest first
    int          m_mode, m_n, m_werr;
    bit          m_hist[$];
    int unsigned m_errcnt, m_bitcnt;
    bit          m_pulse;

    function automatic void model_reset();
        m_mode = 0; m_n = 0; m_werr = 0;
        m_errcnt = 0; m_bitcnt = 0; m_pulse = 1'b0;
        m_hist.delete();
        repeat (32) m_hist.push_back(1'b0);
    endfunction

    function automatic void model_step(input bit en, input bit din, input bit clr);
        bit p, mis, was_locked;
        was_locked = (m_mode == 2);
        m_pulse = 1'b0;
        mis = 1'b0;
        if (en) begin
            p   = m_hist[0] ^ m_hist[10] ^ m_hist[30] ^ m_hist[31];
            mis = (din != p);
            void'(m_hist.pop_front());
            m_hist.push_back(was_locked ? p : din);
            case (m_mode)
                0: begin
                    m_n++;
                    if (m_n == 32) begin m_mode = 1; m_n = 0; end
                end
                1: begin
                    if (mis) begin m_mode = 0; m_n = 0; end
                    else begin
                        m_n++;
                        if (m_n == 32) begin m_mode = 2; m_n = 0; m_werr = 0; end
                    end
                end
                default: begin
                    m_n++;
                    if (mis) begin m_werr++; m_pulse = 1'b1; end
                    if (m_werr >= THRESH) begin m_mode = 0; m_n = 0; m_werr = 0; end
                    else if (m_n == 32) begin m_n = 0; m_werr = 0; end
                end
            endcase
        end
        if (clr) begin
            m_errcnt = 0;
            m_bitcnt = 0;
        end else if (en && was_locked) begin
            m_bitcnt++;
            if (mis && m_errcnt < 32'hFFFF) m_errcnt++;
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input bit en, input bit flip, input bit clr);
        En     = en;
        ClrErr = clr;
        DIn    = en ? (lfsr_step(g) ^ flip) : 1'($urandom);
        @(posedge Clk);
        model_step(en, DIn, clr);
        #1;
        chk("locked",    {31'd0, Locked},   {31'd0, m_mode == 2});
        chk("err_pulse", {31'd0, ErrPulse}, {31'd0, m_pulse});
        chk("err_cnt",   {16'd0, ErrCnt},   m_errcnt);
        chk("bit_cnt",   BitCnt,            BITCNT_ON ? m_bitcnt : 32'd0);
        if (ErrPulse) pulses++;
        En     = 1'b0;
        ClrErr = 1'b0;
    endtask

    task automatic do_reset();
        #2 ARstb = 1'b0;
        model_reset();
        @(posedge Clk);
        #2 ARstb = 1'b1;
    endtask

    task automatic sat_tick(input bit flip, input bit clr);
        s_en  = 1'b1;
        s_clr = clr;
        s_din = lfsr_step(sg) ^ flip;
        @(posedge Clk);
        #1;
        s_clr = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int nhigh;
        vecs[0] = '{"one_err",      1, 1, 1'b1, 1};
        vecs[1] = '{"seven_err",    7, 1, 1'b1, 7};
        vecs[2] = '{"eight_err",    8, 1, 1'b0, 8};
        vecs[3] = '{"eight_gap4",   8, 4, 1'b0, 8};
        vecs[4] = '{"eight_gap5",   8, 5, 1'b1, 8};

        ARstb = 1'b0; En = 1'b0; DIn = 1'b0; ClrErr = 1'b0;
        s_rst = 1'b0; s_en = 1'b0; s_din = 1'b0; s_clr = 1'b0;
        model_reset();
        #1;
        chk("rst_locked",    {31'd0, Locked},   32'd0);
        chk("rst_err_pulse", {31'd0, ErrPulse}, 32'd0);
        chk("rst_err_cnt",   {16'd0, ErrCnt},   32'd0);
        chk("rst_bit_cnt",   BitCnt,            32'd0);

        // sync from a stream seeded 1: Locked high in the 65th cycle after release
        g = 32'h1;
        @(posedge Clk);
        #2 ARstb = 1'b1; s_rst = 1'b1;
        repeat (63) tick(1'b1, 1'b0, 1'b0);
        chk("sync_63_unlocked", {31'd0, Locked}, 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        chk("sync_64_locked",   {31'd0, Locked}, 32'd1);
        chk("sync_err_cnt",     {16'd0, ErrCnt}, 32'd0);

        // ClrErr wins over the same-cycle BitCnt increment, then 1000 locked bits
        tick(1'b1, 1'b0, 1'b1);
        repeat (1000) tick(1'b1, 1'b0, 1'b0);
        chk("bit_cnt_1000", BitCnt, BITCNT_ON ? 32'd1000 : 32'd0);

        // async reset while locked with an error pending on the outputs
        tick(1'b1, 1'b1, 1'b0);
        chk("pre_rst_pulse", {31'd0, ErrPulse}, 32'd1);
        #2 ARstb = 1'b0;
        model_reset();
        #1;
        chk("midrst_locked",    {31'd0, Locked},   32'd0);
        chk("midrst_err_pulse", {31'd0, ErrPulse}, 32'd0);
        chk("midrst_err_cnt",   {16'd0, ErrCnt},   32'd0);
        chk("midrst_bit_cnt",   BitCnt,            32'd0);
        @(posedge Clk);
        #2 ARstb = 1'b1;
        repeat (63) tick(1'b1, 1'b0, 1'b0);
        chk("rst_relock_63", {31'd0, Locked}, 32'd0);
        tick(1'b1, 1'b0, 1'b0);
        chk("rst_relock_64", {31'd0, Locked}, 32'd1);

        // error-injection table, each starting at the first sample of a fresh lock
        for (int v = 0; v < 5; v++) begin
            do_reset();
            repeat (64) tick(1'b1, 1'b0, 1'b0);
            pulses = 0;
            for (int k = 0; k <= (vecs[v].nflip - 1) * vecs[v].gap; k++)
                tick(1'b1, (k % vecs[v].gap) == 0, 1'b0);
            chk({vecs[v].name, "_locked"}, {31'd0, Locked}, {31'd0, vecs[v].exp_locked});
            chk({vecs[v].name, "_errcnt"}, {16'd0, ErrCnt}, vecs[v].exp_err);
            chk({vecs[v].name, "_pulses"}, pulses, vecs[v].nflip);
            if (vecs[v].exp_locked) begin
                repeat (40) tick(1'b1, 1'b0, 1'b0);
                chk({vecs[v].name, "_quiet"}, pulses, vecs[v].nflip);
                chk({vecs[v].name, "_held"}, {31'd0, Locked}, 32'd1);
            end else begin
                repeat (63) tick(1'b1, 1'b0, 1'b0);
                chk({vecs[v].name, "_relock63"}, {31'd0, Locked}, 32'd0);
                tick(1'b1, 1'b0, 1'b0);
                chk({vecs[v].name, "_relock64"}, {31'd0, Locked}, 32'd1);
                chk({vecs[v].name, "_errkept"}, {16'd0, ErrCnt}, vecs[v].exp_err);
            end
        end

        // En toggled at random during sync: lock after exactly 64 En-high samples
        do_reset();
        nhigh = 0;
        for (int i = 0; i < 2000; i++) begin
            bit en;
            en = 1'($urandom);
            tick(en, 1'b0, 1'b0);
            if (en) nhigh++;
            if (Locked) break;
        end
        chk("en_gate_samples", nhigh, 64);

        // random En, line errors and clears against the model
        for (int i = 0; i < 3000; i++)
            tick(($urandom % 10) < 7, ($urandom % 40) == 0, ($urandom % 200) == 0);

        // saturation and ClrErr collision on the never-unlocking instance
        sg = 32'hACE1_2345;
        repeat (64) sat_tick(1'b0, 1'b0);
        chk("sat_locked", {31'd0, s_locked}, 32'd1);
        sat_tick(1'b1, 1'b1);
        chk("clr_collide_cnt",   {16'd0, s_errcnt}, 32'd0);
        chk("clr_collide_pulse", {31'd0, s_pulse},  32'd1);
        repeat (65534) sat_tick(1'b1, 1'b0);
        chk("sat_fffe", {16'd0, s_errcnt}, 32'hFFFE);
        sat_tick(1'b1, 1'b0);
        chk("sat_ffff", {16'd0, s_errcnt}, 32'hFFFF);
        sat_tick(1'b1, 1'b0);
        chk("sat_hold",        {16'd0, s_errcnt}, 32'hFFFF);
        chk("sat_hold_pulse",  {31'd0, s_pulse},  32'd1);
        chk("sat_still_lock",  {31'd0, s_locked}, 32'd1);
        sat_tick(1'b1, 1'b1);
        chk("sat_clr_cnt",     {16'd0, s_errcnt}, 32'd0);
        chk("sat_clr_bitcnt",  s_bitcnt,          32'd0);
        s_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/lfsr32_checker.md
LFSR32_CHECKER -- requirements
Module: lfsr32_checker

Interface
REQ-001 SHALL have ports: Clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: ARstb  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: En  in  1  DIn valid this cycle; no state change when low.
REQ-004 SHALL have ports: DIn  in  1  serial PRBS bit from an lfsr32 LFSR0out/LFSR1out pin.
REQ-005 SHALL have ports: ClrErr  in  1  synchronous clear of ErrCnt (and BitCnt).
REQ-006 SHALL have ports: Locked  out  1  high only in state LOCKED.
REQ-007 SHALL have ports: ErrPulse  out  1  registered, one cycle high per mismatch while LOCKED.
REQ-008 SHALL have ports: ErrCnt  out  16  saturating count of mismatches while LOCKED.
REQ-009 SHALL have ports: BitCnt  out  32  bits checked while LOCKED (see Configuration).
REQ-010 SHALL have parameters: ERR_THRESH, default 8, mismatches within a 32-bit window that force loss of lock.

Function
REQ-011 SHALL use polynomial x^32+x^22+x^2+x+1: with history H[31:0] (H[0] newest), predicted bit P = H[31]^H[21]^H[1]^H[0].
REQ-012 SHALL implement FSM SEED -> VERIFY -> LOCKED; every transition, shift and count occurs only on cycles with En=1.
REQ-013 SHALL, in SEED, shift DIn into H and count 32 bits, then enter VERIFY with the match counter cleared.
REQ-014 SHALL, in VERIFY, compare DIn to P and shift DIn into H; 32 consecutive matches -> LOCKED; any mismatch -> SEED, seed counter cleared.
REQ-015 SHALL, in LOCKED, shift P (not DIn) into H, so single line errors do not propagate.
REQ-016 SHALL, in LOCKED, on a mismatch, pulse ErrPulse the following cycle and increment ErrCnt, saturating at 0xFFFF.
REQ-017 SHALL track a 32-bit window in LOCKED; reaching ERR_THRESH mismatches within one window -> SEED next cycle, Locked low, window restarts.
REQ-018 SHALL give ClrErr priority over a same-cycle increment: ErrCnt=0 and BitCnt=0 after that edge.
REQ-019 SHALL have Locked/ErrPulse latency of exactly one Clk after the deciding En-qualified sample.
REQ-020 SHALL keep ErrCnt/BitCnt values across loss of lock; only ClrErr or reset clears them.

Reset
REQ-021 SHALL, on ARstb low, asynchronously force state SEED, H=0, all internal counters 0, Locked=0, ErrPulse=0, ErrCnt=0, BitCnt=0.
REQ-022 SHALL treat ARstb asserted mid-operation identically; deassertion leaves the FSM in SEED awaiting 32 fresh bits.

Configuration
REQ-023 SHALL, with LFSR32_CHK_BITCNT_EN defined, count En-qualified LOCKED bits in BitCnt, wrapping at 2^32.
REQ-024 SHALL, without LFSR32_CHK_BITCNT_EN, keep the BitCnt port and drive it constant 0 with no counter flops.

Structure
REQ-025 SHALL place the tap constants (31,21,1,0), the width 32 and the FSM state enum in the shared package lfsr32_pkg.
REQ-026 SHALL keep the 32-bit prediction/history register in one sub-module lfsr32_predict (shift, load-select, P output); FSM and counters live in the top.

Verification
REQ-027 SHALL test sync: drive lfsr32 stream seeded 0x00000001, En=1 -> Locked rises exactly 65 cycles after reset release, ErrCnt=0.
REQ-028 SHALL test single error: invert one bit after lock -> one ErrPulse, ErrCnt=1, Locked stays 1, no further errors.
REQ-029 SHALL test loss: invert 8 bits within 32 after lock -> Locked falls, relocks 64 En cycles later, ErrCnt=8.
REQ-030 SHALL test En gating: toggle En 50% random during sync -> lock after exactly 64 En-high samples; held state when En=0.
REQ-031 SHALL test ClrErr collision: ClrErr on the same cycle as a mismatch -> ErrCnt=0; ErrCnt at 0xFFFF plus one more error -> stays 0xFFFF.
REQ-032 SHALL test reset: ARstb low mid-LOCKED -> all outputs 0 immediately; with the macro, 1000 locked bits -> BitCnt=1000; without it, BitCnt=0.
